rr_mux_arbiter: RTL

- Round-robin arbiter and sequencer for a shared N:1 data multiplexer.
- NUM_REQ requesters compete for one output channel.
- The block grants one requester at a time, drives the mux select, and forwards the winner's data with a valid flag.
- Sits in front of the shared mux datapath as its only select source.

---
 rtl/rr_mux_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter and select sequencer for a shared N:1 data mux.
// Optional forced-release timeout is built only when ARB_TIMEOUT_EN is defined.
module rr_mux_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 2,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic [SEL_W-1:0]          sel,
    output logic                      busy,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      timeout
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_bad_num_req
        $error("rr_mux_arbiter: NUM_REQ must be a power of 2 in 2..8");
    end
    if (SEL_W != $clog2(NUM_REQ)) begin : g_bad_sel_w
        $error("rr_mux_arbiter: SEL_W must equal log2(NUM_REQ)");
    end
    if (HOLD_MAX < 2) begin : g_bad_hold_max
        $error("rr_mux_arbiter: HOLD_MAX must be >= 2");
    end

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;

    logic                 win_found;
    logic [SEL_W-1:0]     win_idx;
    logic [SEL_W-1:0]     cand;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX);
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
`endif

    // SEL_W-bit addition wraps modulo NUM_REQ since NUM_REQ is a power of 2
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + SEL_W'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    grant_d = NUM_REQ'(1) << win_idx;
                    sel_d   = win_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + SEL_W'(1);
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_d     = sel_q + SEL_W'(1);
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign busy      = (state_q == GRANT);
    assign out_valid = busy & req[sel_q];
    assign out_data  = data_in[sel_q*DATA_W +: DATA_W];

endmodule
